// File: rtl/rf_loader.sv
// rf_loader: loads one tile of stream pixels into a 32-entry register file.
// Build with RF_LOADER_PAD_EN defined to zero-pad short tiles up to the target length.
module rf_loader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            cfg_count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  rf_en,
  output logic                  rf_wr_ctrl,
  output logic [4:0]            rf_add_in,
  output logic [DATA_WIDTH-1:0] rf_in,
  output logic                  tile_valid,
  input  logic                  tile_release,
  output logic [5:0]            fill_count,
  output logic                  busy
);

`ifdef RF_LOADER_PAD_EN
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PAD, S_FLUSH, S_DONE} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_FLUSH, S_DONE} state_e;
`endif

  state_e                state_q;
  logic [5:0]            target_q;
  logic [4:0]            wr_ptr_q;
  logic [5:0]            fill_count_q;
  logic                  in_ready_q;
  logic                  wr_q;
  logic [4:0]            addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  tile_valid_q;
  logic                  busy_q;

  logic [5:0] target_d;
  logic [4:0] wr_ptr_d;
  logic       last_beat_d;

  // A length of 0 or anything beyond the register file depth means a full tile.
  assign target_d    = (cfg_count == 6'd0 || cfg_count > 6'd32) ? 6'd32 : cfg_count;
  assign wr_ptr_d    = (wr_ptr_q == 5'd31) ? wr_ptr_q : wr_ptr_q + 5'd1;
  assign last_beat_d = ((fill_count_q + 6'd1) == target_q);

`ifdef RF_LOADER_PAD_EN
  logic pad_last_d;
  assign pad_last_d = ({1'b0, wr_ptr_q} == (target_q - 6'd1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      target_q     <= 6'd32;
      wr_ptr_q     <= 5'd0;
      fill_count_q <= 6'd0;
      in_ready_q   <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 5'd0;
      data_q       <= '0;
      tile_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            target_q     <= target_d;
            wr_ptr_q     <= 5'd0;
            fill_count_q <= 6'd0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_FILL;
          end
        end
        S_FILL: begin
          if (in_valid) begin
            wr_q         <= 1'b1;
            addr_q       <= wr_ptr_q;
            data_q       <= in_data;
            wr_ptr_q     <= wr_ptr_d;
            fill_count_q <= fill_count_q + 6'd1;
            if (last_beat_d) begin
              in_ready_q <= 1'b0;
              state_q    <= S_FLUSH;
            end else if (in_last) begin
              in_ready_q <= 1'b0;
`ifdef RF_LOADER_PAD_EN
              state_q    <= S_PAD;
`else
              state_q    <= S_FLUSH;
`endif
            end
          end
        end
`ifdef RF_LOADER_PAD_EN
        S_PAD: begin
          wr_q     <= 1'b1;
          addr_q   <= wr_ptr_q;
          data_q   <= '0;
          wr_ptr_q <= wr_ptr_d;
          if (pad_last_d) state_q <= S_FLUSH;
        end
`endif
        // The last write strobe is on the bus during this cycle; the tile is
        // only advertised once that write has landed.
        S_FLUSH: begin
          tile_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          if (tile_release) begin
            tile_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rf_en      = 1'b1;
  assign in_ready   = in_ready_q;
  assign rf_wr_ctrl = wr_q;
  assign rf_add_in  = addr_q;
  assign rf_in      = data_q;
  assign tile_valid = tile_valid_q;
  assign fill_count = fill_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rf_loader.sv
// Testbench for rf_loader: table of tile scenarios with randomized stream gaps,
// expected write sequence derived from tile length/in_last rules, plus reset and DONE corner cases.
module tb_rf_loader;
  localparam int DW = 8;
`ifdef RF_LOADER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [5:0]    cfg_count;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          rf_en;
  logic          rf_wr_ctrl;
  logic [4:0]    rf_add_in;
  logic [DW-1:0] rf_in;
  logic          tile_valid;
  logic          tile_release;
  logic [5:0]    fill_count;
  logic          busy;

  rf_loader #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_count(cfg_count),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .rf_en(rf_en), .rf_wr_ctrl(rf_wr_ctrl), .rf_add_in(rf_add_in), .rf_in(rf_in),
    .tile_valid(tile_valid), .tile_release(tile_release), .fill_count(fill_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] beat_data [32];

  typedef struct {
    int cfg;
    int last_at;   // beat index carrying in_last, 99 = never
    int gap_pct;
    int exp_tgt;
    int exp_fill;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_wr"}, 32'(rf_wr_ctrl), 0);
    chk({tag, "_rf_en"}, 32'(rf_en), 1);
    chk({tag, "_addr"}, 32'(rf_add_in), 0);
    chk({tag, "_data"}, 32'(rf_in), 0);
    chk({tag, "_tile_valid"}, 32'(tile_valid), 0);
    chk({tag, "_fill"}, 32'(fill_count), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One tile from start to DONE, then release with start held high.
  task automatic run_tile(input int cfg, input int last_at, input int gap_pct,
                          input int tgt, input int nreal);
    int k, cyc, pad, last_addr;
    bit acc_prev, v;
    logic [DW-1:0] last_data;
    pad = PAD_EN ? (tgt - nreal) : 0;
    start = 1'b1; cfg_count = 6'(cfg);
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    k = 0; cyc = 0; acc_prev = 1'b0;
    while (k < nreal) begin
      if (acc_prev) begin
        chk("fill_wr", 32'(rf_wr_ctrl), 1);
        chk("fill_addr", 32'(rf_add_in), 32'(k - 1));
        chk("fill_data", 32'(rf_in), 32'(beat_data[k-1]));
      end else begin
        chk("gap_no_wr", 32'(rf_wr_ctrl), 0);
      end
      chk("fill_ready", 32'(in_ready), 1);
      chk("fill_count_run", 32'(fill_count), 32'(k));
      v = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data = v ? beat_data[k] : DW'($urandom);
      in_last = v ? (k == last_at) : 1'($urandom);
      start = 1'($urandom);
      tile_release = 1'($urandom);
      acc_prev = v;
      if (v) k++;
      cyc++;
      @(negedge clk);
      if (cyc > 600) begin
        chk("fill_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0; tile_release = 1'b0;
    chk("final_wr", 32'(rf_wr_ctrl), 1);
    chk("final_addr", 32'(rf_add_in), 32'(nreal - 1));
    chk("final_data", 32'(rf_in), 32'(beat_data[nreal-1]));
    chk("final_ready", 32'(in_ready), 0);
    chk("final_fill", 32'(fill_count), 32'(nreal));
    for (int p = 0; p < pad; p++) begin
      chk("pad_tv_low", 32'(tile_valid), 0);
      @(negedge clk);
      chk("pad_wr", 32'(rf_wr_ctrl), 1);
      chk("pad_addr", 32'(rf_add_in), 32'(nreal + p));
      chk("pad_data", 32'(rf_in), 0);
      chk("pad_ready", 32'(in_ready), 0);
    end
    chk("flush_tv_low", 32'(tile_valid), 0);
    @(negedge clk);
    last_addr = nreal - 1 + pad;
    last_data = (pad > 0) ? '0 : beat_data[nreal-1];
    chk("done_tv", 32'(tile_valid), 1);
    chk("done_no_wr", 32'(rf_wr_ctrl), 0);
    chk("done_fill", 32'(fill_count), 32'(nreal));
    chk("done_ready", 32'(in_ready), 0);
    chk("done_addr_hold", 32'(rf_add_in), 32'(last_addr));
    chk("done_data_hold", 32'(rf_in), 32'(last_data));
    start = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("done_start_ignored_tv", 32'(tile_valid), 1);
      chk("done_start_ignored_busy", 32'(busy), 1);
    end
    tile_release = 1'b1;
    @(negedge clk);
    chk("release_tv", 32'(tile_valid), 0);
    chk("release_busy", 32'(busy), 0);
    chk("release_ready", 32'(in_ready), 0);
    start = 1'b0; tile_release = 1'b0;
    @(negedge clk);
    chk("idle_no_refill_busy", 32'(busy), 0);
    chk("idle_no_refill_ready", 32'(in_ready), 0);
  endtask

  initial begin
    vecs[0] = '{cfg: 4,  last_at: 99, gap_pct: 0,  exp_tgt: 4,  exp_fill: 4};
    vecs[1] = '{cfg: 0,  last_at: 99, gap_pct: 40, exp_tgt: 32, exp_fill: 32};
    vecs[2] = '{cfg: 8,  last_at: 2,  gap_pct: 0,  exp_tgt: 8,  exp_fill: 3};
    vecs[3] = '{cfg: 40, last_at: 9,  gap_pct: 25, exp_tgt: 32, exp_fill: 10};
    vecs[4] = '{cfg: 1,  last_at: 99, gap_pct: 50, exp_tgt: 1,  exp_fill: 1};
    vecs[5] = '{cfg: 5,  last_at: 4,  gap_pct: 0,  exp_tgt: 5,  exp_fill: 5};
    vecs[6] = '{cfg: 32, last_at: 31, gap_pct: 20, exp_tgt: 32, exp_fill: 32};
    vecs[7] = '{cfg: 63, last_at: 0,  gap_pct: 0,  exp_tgt: 32, exp_fill: 1};

    rst = 1'b1; start = 1'b0; cfg_count = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; tile_release = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("post_rst");

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 32; j++) beat_data[j] = DW'($urandom);
      if (i == 0) begin
        beat_data[0] = 8'h11; beat_data[1] = 8'h22;
        beat_data[2] = 8'h33; beat_data[3] = 8'h44;
      end
      run_tile(vecs[i].cfg, vecs[i].last_at, vecs[i].gap_pct, vecs[i].exp_tgt, vecs[i].exp_fill);
    end

    // Reset in the middle of a six-beat tile, with a write strobe on the bus.
    start = 1'b1; cfg_count = 6'd6;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
    @(negedge clk);
    in_data = 8'hA2;
    @(negedge clk);
    chk("mid_wr_before_rst", 32'(rf_wr_ctrl), 1);
    chk("mid_addr_before_rst", 32'(rf_add_in), 1);
    in_data = 8'hA3;
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("after_rst_no_wr", 32'(rf_wr_ctrl), 0);
      chk("after_rst_ready", 32'(in_ready), 0);
      chk("after_rst_busy", 32'(busy), 0);
    end
    in_valid = 1'b0;

    for (int j = 0; j < 32; j++) beat_data[j] = DW'($urandom);
    run_tile(3, 99, 10, 3, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_loader.md
RF_LOADER -- requirements
Module: rf_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of pixel data and register-file write data.
REQ-002 SHALL have one clock, clk, and one reset, rst, which is asynchronous and active-high.
REQ-003 SHALL have ports, one per line as name, direction, width, meaning:
clk  in  1  clock, rising edge
rst  in  1  async active-high reset
start  in  1  begin loading one tile (sampled in IDLE only)
cfg_count  in  6  tile length in words; 1..32, 0 or >32 treated as 32
in_valid  in  1  stream beat valid
in_data  in  DATA_WIDTH  stream pixel
in_last  in  1  final beat of stream segment
in_ready  out  1  loader accepts beat
rf_en  out  1  register-file enable
rf_wr_ctrl  out  1  register-file write strobe
rf_add_in  out  5  register-file write address
rf_in  out  DATA_WIDTH  register-file write data
tile_valid  out  1  tile resident in register file, readable
tile_release  in  1  consumer finished with tile
fill_count  out  6  real stream beats written this tile
busy  out  1  state != IDLE

Function
REQ-004 SHALL implement states IDLE, FILL, PAD, FLUSH, DONE; PAD exists only with RF_LOADER_PAD_EN.
REQ-005 IDLE: in_ready=0; start=1 latches sanitized cfg_count as target, clears wr_ptr and fill_count, enters FILL next cycle.
REQ-006 start SHALL be ignored in every state other than IDLE, including DONE with tile_release=1.
REQ-007 FILL: in_ready=1; a beat is accepted when in_valid&&in_ready.
REQ-008 Accepted beat SHALL produce, registered one cycle later, rf_wr_ctrl=1, rf_add_in=wr_ptr, rf_in=in_data; wr_ptr and fill_count increment.
REQ-009 rf_wr_ctrl SHALL be 0 on every cycle without a write; rf_add_in and rf_in hold their last values then.
REQ-010 rf_en SHALL be 1 in all states and during reset, so the register file's clear path and writes are always enabled.
REQ-011 Accepting beat number target SHALL move FILL->FLUSH regardless of in_last.
REQ-012 in_last on a beat with fill_count+1 < target SHALL move FILL->PAD if RF_LOADER_PAD_EN is defined, else FILL->FLUSH.
REQ-013 FLUSH SHALL last exactly one cycle (final write strobe visible), then DONE.
REQ-014 DONE: tile_valid=1, in_ready=0, held until tile_release=1; then IDLE next cycle with tile_valid=0.
REQ-015 tile_valid SHALL rise two cycles after the final beat is accepted (no pad), i.e. after the write has landed.
REQ-016 wr_ptr SHALL never exceed 31; no wrap-around inside one tile.
REQ-017 tile_release outside DONE SHALL be ignored.

Reset
REQ-018 rst SHALL force IDLE, in_ready=0, rf_wr_ctrl=0, rf_en=1, rf_add_in=0, rf_in=0, tile_valid=0, fill_count=0, busy=0, asynchronously.
REQ-019 rst mid-FILL/PAD SHALL abandon the partial tile; no further write strobes after rst asserts.

Configuration
REQ-020 Macro RF_LOADER_PAD_EN defined: PAD writes 0 to addresses wr_ptr..target-1, one per cycle, rf_wr_ctrl=1, in_ready=0, then FLUSH; fill_count excludes padded words.
REQ-021 Macro RF_LOADER_PAD_EN undefined: PAD state and logic absent; short tile goes straight to FLUSH, remaining addresses keep stale contents.

Verification
REQ-022 start, cfg_count=4, beats 0x11,0x22,0x33,0x44 back-to-back -> writes addr 0..3 cycles 1..4 after acceptance each, tile_valid two cycles after 4th beat, fill_count=4.
REQ-023 cfg_count=0, 32 beats with random in_valid gaps -> addresses 0..31 each written once, no write on gap cycles, fill_count=32.
REQ-024 cfg_count=8, in_last on 3rd beat, PAD_EN defined -> addr 3..7 written 0, fill_count=3; undefined -> only 3 writes, tile_valid, fill_count=3.
REQ-025 In DONE, start=1 with tile_release=1 -> IDLE, no new fill; start next cycle -> FILL.
REQ-026 rst pulse after 2 of 6 beats -> all outputs at reset values same cycle, no further rf_wr_ctrl, in_ready=0 until new start.
